sfr_write_issuer: RTL

Initiator side of the SFR write interface: accepts CPU direct-address SFR write requests through a valid/ready handshake and buffers them in a small FIFO. It decodes each address against a slot table and drives the one-hot operation strobe and byte that SFR register blocks consume (write the byte when their op bit is set). Bit-addressable operations (SETB/CLR/CPL) are resolved here by read-modify-write against the registers' current values, with forwarding for back-to-back writes to the same slot. It sits between the core's execute stage and the SFR register bank.

---
 rtl/sfr_write_issuer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sfr_write_issuer.sv
// SFR write issuer: buffers CPU direct-address SFR writes in a small FIFO,
// decodes each head entry against a slot table and drives a one-hot write
// strobe plus byte. Bit operations are resolved by read-modify-write, with
// forwarding from the previous issue when it targeted the same slot.
module sfr_write_issuer #(
    parameter int unsigned              NUM_SLOTS  = 4,
    parameter logic [8*NUM_SLOTS-1:0]   SLOT_ADDRS = {8'hB0, 8'hA0, 8'h90, 8'h80},
    parameter int unsigned              FIFO_DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req,
    output logic                   o_ready,
    input  logic [7:0]             i_addr,
    input  logic [7:0]             i_data,
    input  logic [1:0]             i_mode,
    input  logic [8*NUM_SLOTS-1:0] i_rd_bus,
    output logic [7:0]             o_byte,
    output logic [NUM_SLOTS-1:0]   o_op,
    output logic                   o_miss,
    output logic                   o_busy
);

    localparam int unsigned   PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned   SlotW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [PtrW:0] CntMax = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [PtrW:0] CntOne = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    typedef enum logic [1:0] {
        ModeByte = 2'b00,
        ModeSet  = 2'b01,
        ModeClr  = 2'b10,
        ModeTgl  = 2'b11
    } mode_e;

    // FIFO entry layout: {addr[7:0], data[7:0], mode[1:0]}
    logic [17:0]          mem [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]        count_q, count_d;
    logic                 push, pop;

    logic [7:0]           head_addr, head_data;
    mode_e                head_mode;
    logic                 hit;
    logic [SlotW-1:0]     slot;
    logic [7:0]           base, bit_mask, new_byte;

    logic [NUM_SLOTS-1:0] op_q;
    logic [7:0]           byte_q;
    logic                 miss_q;

    assign o_ready   = (count_q < CntMax);
    assign push      = i_req & o_ready;
    assign pop       = (count_q != '0);

    assign head_addr = mem[rd_ptr_q][17:10];
    assign head_data = mem[rd_ptr_q][9:2];
    assign head_mode = mode_e'(mem[rd_ptr_q][1:0]);

    // FIFO storage write; contents need no reset since count gates every read
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {i_addr, i_data, i_mode};
        end
    end

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and count; pointers wrap naturally as depth is a power of two
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q <= count_d;
        end
    end

    // Address decode; scanning downward lets the lowest matching index win
    always_comb begin
        hit  = 1'b0;
        slot = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (head_addr == SLOT_ADDRS[8*i +: 8]) begin
                hit  = 1'b1;
                slot = SlotW'(i);
            end
        end
    end

    // Read-modify-write value; the register lags the strobe by one edge, so a
    // write issued last cycle to the same slot is taken from o_byte instead
    always_comb begin
        base     = op_q[slot] ? byte_q : i_rd_bus[{slot, 3'b000} +: 8];
        bit_mask = 8'h01 << head_data[2:0];
        new_byte = head_data;
        case (head_mode)
            ModeByte: new_byte = head_data;
            ModeSet:  new_byte = base | bit_mask;
            ModeClr:  new_byte = base & ~bit_mask;
            ModeTgl:  new_byte = base ^ bit_mask;
            default:  new_byte = head_data;
        endcase
    end

    // Issue stage: pop the head every non-empty cycle and register the result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q   <= '0;
            byte_q <= 8'h00;
            miss_q <= 1'b0;
        end else if (pop) begin
            op_q   <= hit ? (NUM_SLOTS'(1) << slot) : '0;
            miss_q <= ~hit;
            if (hit) byte_q <= new_byte;
        end else begin
            op_q   <= '0;
            miss_q <= 1'b0;
        end
    end

    assign o_op   = op_q;
    assign o_byte = byte_q;
    assign o_miss = miss_q;
    assign o_busy = (count_q != '0) | (|op_q) | miss_q;

endmodule
